ex_iter_alu: RTL and testbench
==============================

Name: ex_iter_alu

Overview:
- Parametrised next-generation execute unit for the ex stage.
- Generalises the fixed-width single-cycle ALU/EFLAG path to a configurable DATA_W datapath.
- Adds an iterative shifter and an iterative BSF scanner, which take multiple cycles.
- Uses valid/ready handshakes upstream and downstream, with an internal masked EFLAGS register committed on result handoff.

Parameters:
DATA_W, 32, operand/result width; legal values 16, 32, 64
BSF_STRIDE, 4, source bits examined per BSF cycle; must divide DATA_W, power of 2
CNT_W, 6, shift-count field width; only the low log2(DATA_W) bits are used

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
valid_in  input  1  operation offered
ready_out  output  1  unit can accept (state IDLE)
op  input  3  000 ADD, 001 AND, 010 OR, 011 NOT, 100 SAL, 101 SAR, 110 BSF, 111 PASS
op1  input  DATA_W  destination/first operand
op2  input  DATA_W  source operand (BSF source)
shcnt  input  CNT_W  shift count
fmask  input  18  per-bit EFLAGS write enable
flush  input  1  abort in-flight op
valid_out  output  1  result available
ready_in  input  1  downstream accepts result
result  output  DATA_W  result
eflags  output  18  architectural flags: bit0 CF, 1 PF, 2 AF, 3 ZF, 4 SF, 7 DF, 8 OF; other bits 0
busy  output  1  state BUSY

Behaviour:
- Reset (rst=1 at posedge): state IDLE, valid_out=0, result=0, eflags=0, busy=0, ready_out=1. Reset mid-op discards the op with no flag write.
- FSM states: IDLE, BUSY, DONE.
- IDLE: accept when valid_in & ready_out and no flush.
  - ADD/AND/OR/NOT/PASS go to DONE; valid_out rises the next cycle (latency 1).
  - SAL/SAR with masked count c=0 go to DONE with result=op1 and no flag update.
  - SAL/SAR with c>0 go to BUSY and shift 1 bit per cycle; DONE after c cycles (valid_out at c+1).
  - BSF: if op2==0, go to DONE after DATA_W/BSF_STRIDE scan cycles. Otherwise scan BSF_STRIDE bits per cycle from bit 0 and reach DONE in the cycle the lowest set bit is found, i.e. floor(idx/BSF_STRIDE)+1 cycles; valid_out follows at floor(idx/BSF_STRIDE)+2.
- DONE: result held stable while valid_out=1 && ready_in=0. When valid_out & ready_in:
  - eflags[i] <= fmask[i] ? newflag[i] : eflags[i], restricted further by the per-op flag set below;
  - state goes to IDLE;
  - ready_out returns high the following cycle, so there is no back-to-back accept in the same cycle as handoff.
- Flags per op (bits outside the listed set are never written regardless of fmask):
  - ADD: CF = carry out of MSB; OF = signed overflow; AF = carry from bit3; ZF; SF = MSB; PF = even parity of result[7:0].
  - AND/OR: CF=OF=AF=0; ZF, SF, PF from result.
  - NOT, PASS: no flags.
  - SAL/SAR with c>0: CF = last bit shifted out; ZF, SF, PF from result. OF written only when c=1: SAL gives MSB(result)^CF, SAR gives 0. AF not written.
  - BSF: ZF = (op2==0); result = index of lowest set bit, zero-extended, or op1 unchanged when op2==0. Only ZF is written.
- SAR shifts in sign bit; SAL shifts in 0. Count masked to log2(DATA_W) bits before use; widths above DATA_W never occur.
- flush: in BUSY or DONE returns to IDLE next cycle, valid_out=0, no flag write. In IDLE it blocks acceptance that cycle. flush has priority over a simultaneous ready_in handoff.
- busy=1 only in BUSY; ready_out=1 only in IDLE.

Test Plan:
- DATA_W=32: ADD op1=0x7FFFFFFF, op2=1, fmask=all 1 -> result 0x80000000 after 1 cycle; on handoff CF=0, OF=1, SF=1, ZF=0, AF=1, PF=1.
- SAL op1=0x80000001, shcnt=1 -> valid_out at cycle 2, result 0x00000002, CF=1, OF=1. Repeat with shcnt=33 (masked to 1) -> identical result.
- SAR op1=0x80000000, shcnt=4 -> valid_out at cycle 5, result 0xF8000000, CF=0, OF unchanged from prior value.
- BSF op2=0x00000100, STRIDE=4 -> result 8, valid_out at cycle 4, ZF=0. BSF op2=0 -> result=op1, ZF=1, valid_out at cycle 9.
- Backpressure: hold ready_in=0 for 5 cycles after ADD -> result stable, eflags unchanged until the handoff cycle; then ready_out=1 one cycle later.
- flush during a SAL with shcnt=10 at cycle 3 -> valid_out never rises, eflags unchanged, ready_out=1 next cycle. Also assert rst mid-BSF -> all outputs at reset values.

Source files
------------

// File: rtl/ex_iter_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_iter_alu_if
// Description : Operation/result handshake bundle for the iterative ex-stage ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_iter_alu_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
);
    logic              valid_in;
    logic              ready_out;
    logic [2:0]        op;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [CNT_W-1:0]  shcnt;
    logic [17:0]       fmask;
    logic              flush;
    logic              valid_out;
    logic              ready_in;
    logic [DATA_W-1:0] result;
    logic [17:0]       eflags;
    logic              busy;

    modport master (
        output valid_in, op, op1, op2, shcnt, fmask, flush, ready_in,
        input  ready_out, valid_out, result, eflags, busy
    );

    modport slave (
        input  valid_in, op, op1, op2, shcnt, fmask, flush, ready_in,
        output ready_out, valid_out, result, eflags, busy
    );
endinterface
`default_nettype wire

// File: rtl/ex_iter_alu.sv
`default_nettype none
// ============================================================================
// Module      : ex_iter_alu
// Description : DATA_W execute unit: single-cycle ALU ops, 1-bit/cycle shifter,
//               BSF_STRIDE-bit/cycle BSF scanner, masked EFLAGS on handoff.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_iter_alu #(
    parameter int DATA_W     = 32,
    parameter int BSF_STRIDE = 4,
    parameter int CNT_W      = 6
) (
    input wire           clk,
    input wire           rst,
    ex_iter_alu_if.slave bus
);
    localparam int SH_W = $clog2(DATA_W);

    localparam logic [2:0] c_op_add  = 3'b000;
    localparam logic [2:0] c_op_and  = 3'b001;
    localparam logic [2:0] c_op_or   = 3'b010;
    localparam logic [2:0] c_op_not  = 3'b011;
    localparam logic [2:0] c_op_sal  = 3'b100;
    localparam logic [2:0] c_op_sar  = 3'b101;
    localparam logic [2:0] c_op_bsf  = 3'b110;

    localparam logic [17:0] c_set_arith = 18'h0011F;  // CF PF AF ZF SF OF
    localparam logic [17:0] c_set_shift = 18'h0001B;  // CF PF ZF SF
    localparam logic [17:0] c_flag_of   = 18'h00100;
    localparam logic [17:0] c_flag_zf   = 18'h00008;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_handoff;
    logic              w_step;

    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_src;
    logic [SH_W-1:0]   r_cnt;
    logic [SH_W-1:0]   r_pos;
    logic              r_cf;
    logic              r_of;
    logic              r_af;
    logic              r_bsf_zero;
    logic [17:0]       r_fwe;
    logic [17:0]       r_eflags;

    logic [SH_W-1:0]   w_cnt;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_ld_result;
    logic              w_ld_cf;
    logic              w_ld_of;
    logic              w_ld_af;
    logic [17:0]       w_ld_set;
    logic              w_hit;
    logic [SH_W-1:0]   w_hit_off;
    logic [SH_W-1:0]   w_bsf_idx;
    logic              w_last_chunk;
    logic [17:0]       w_newflags;

    assign w_cnt        = bus.shcnt[SH_W-1:0];
    assign w_sum        = {1'b0, bus.op1} + {1'b0, bus.op2};
    assign w_bsf_idx    = r_pos + w_hit_off;
    assign w_last_chunk = (r_pos == SH_W'(DATA_W - BSF_STRIDE));

    generate
        if (CNT_W > SH_W) begin : g_cnt_hi
            logic w_unused_cnt_hi;
            assign w_unused_cnt_hi = |bus.shcnt[CNT_W-1:SH_W];
        end
    endgenerate

    // Lowest set bit of the chunk currently at the bottom of r_src.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_off = '0;
        for (int k = BSF_STRIDE - 1; k >= 0; k--) begin
            if (r_src[k]) begin
                w_hit     = 1'b1;
                w_hit_off = SH_W'(k);
            end
        end
    end

    always_comb begin
        w_ld_result = bus.op1;
        w_ld_cf     = 1'b0;
        w_ld_of     = 1'b0;
        w_ld_af     = 1'b0;
        w_ld_set    = '0;
        case (bus.op)
            c_op_add: begin
                w_ld_result = w_sum[DATA_W-1:0];
                w_ld_cf     = w_sum[DATA_W];
                w_ld_of     = (bus.op1[DATA_W-1] == bus.op2[DATA_W-1]) &&
                              (w_sum[DATA_W-1] != bus.op1[DATA_W-1]);
                w_ld_af     = bus.op1[4] ^ bus.op2[4] ^ w_sum[4];
                w_ld_set    = c_set_arith;
            end
            c_op_and: begin
                w_ld_result = bus.op1 & bus.op2;
                w_ld_set    = c_set_arith;
            end
            c_op_or: begin
                w_ld_result = bus.op1 | bus.op2;
                w_ld_set    = c_set_arith;
            end
            c_op_not: w_ld_result = ~bus.op1;
            c_op_sal, c_op_sar: begin
                // OF for a single-bit SAL is MSB^CF of the shifted value, known up front.
                w_ld_of = (bus.op == c_op_sal) && (bus.op1[DATA_W-1] ^ bus.op1[DATA_W-2]);
                if (w_cnt != '0)
                    w_ld_set = c_set_shift | ((w_cnt == SH_W'(1)) ? c_flag_of : 18'h0);
            end
            c_op_bsf: w_ld_set = c_flag_zf;
            default:  w_ld_result = bus.op2;  // PASS moves the source operand
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_handoff   = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.valid_in && !bus.flush) begin
                    w_accept = 1'b1;
                    if (bus.op == c_op_bsf ||
                        ((bus.op == c_op_sal || bus.op == c_op_sar) && w_cnt != '0))
                        w_state_nxt = S_BUSY;
                    else
                        w_state_nxt = S_DONE;
                end
            end
            S_BUSY: begin
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_op == c_op_bsf) begin
                        if (w_hit || w_last_chunk)
                            w_state_nxt = S_DONE;
                    end else if (r_cnt == SH_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.ready_in) begin
                    w_handoff   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_newflags    = '0;
        w_newflags[0] = r_cf;
        w_newflags[1] = ~^r_result[7:0];
        w_newflags[2] = r_af;
        w_newflags[3] = (r_op == c_op_bsf) ? r_bsf_zero : (r_result == '0);
        w_newflags[4] = r_result[DATA_W-1];
        w_newflags[8] = r_of;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= '0;
            r_result   <= '0;
            r_src      <= '0;
            r_cnt      <= '0;
            r_pos      <= '0;
            r_cf       <= 1'b0;
            r_of       <= 1'b0;
            r_af       <= 1'b0;
            r_bsf_zero <= 1'b0;
            r_fwe      <= '0;
            r_eflags   <= '0;
        end else begin
            if (w_accept) begin
                r_op       <= bus.op;
                r_result   <= w_ld_result;
                r_src      <= bus.op2;
                r_cnt      <= w_cnt;
                r_pos      <= '0;
                r_cf       <= w_ld_cf;
                r_of       <= w_ld_of;
                r_af       <= w_ld_af;
                r_bsf_zero <= (bus.op2 == '0);
                r_fwe      <= bus.fmask & w_ld_set;
            end else if (w_step) begin
                if (r_op == c_op_bsf) begin
                    if (w_hit)
                        r_result <= {{(DATA_W-SH_W){1'b0}}, w_bsf_idx};
                    r_src <= r_src >> BSF_STRIDE;
                    r_pos <= r_pos + SH_W'(BSF_STRIDE);
                end else begin
                    if (r_op == c_op_sar) begin
                        r_result <= {r_result[DATA_W-1], r_result[DATA_W-1:1]};
                        r_cf     <= r_result[0];
                    end else begin
                        r_result <= {r_result[DATA_W-2:0], 1'b0};
                        r_cf     <= r_result[DATA_W-1];
                    end
                    r_cnt <= r_cnt - SH_W'(1);
                end
            end
            if (w_handoff)
                r_eflags <= (r_eflags & ~r_fwe) | (w_newflags & r_fwe);
        end
    end

    assign bus.ready_out = (r_state == S_IDLE);
    assign bus.busy      = (r_state == S_BUSY);
    assign bus.valid_out = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.eflags    = r_eflags;
endmodule
`default_nettype wire

// File: tb/tb_ex_iter_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_iter_alu
// Description : Self-checking bench for ex_iter_alu with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_iter_alu;
    localparam int W = 32;
    localparam logic [17:0] F_CF = 18'h1, F_PF = 18'h2, F_AF = 18'h4,
                            F_ZF = 18'h8, F_SF = 18'h10, F_OF = 18'h100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    logic [17:0] exp_eflags = '0;

    always #5 clk = ~clk;

    ex_iter_alu_if #(.DATA_W(W), .CNT_W(6)) bus ();

    ex_iter_alu #(.DATA_W(W), .BSF_STRIDE(4), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Architectural behaviour: result, candidate flags, writable set, cycles to valid_out.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [5:0] sh, output logic [31:0] res,
                                  output logic [17:0] nf, output logic [17:0] wr, output int lat);
        int c;
        int idx;
        logic cf, of, af;
        logic [32:0] wide;
        c = int'(sh) % W;
        cf = 0; of = 0; af = 0; wr = '0; lat = 1; res = a;
        case (o)
            3'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                res = wide[31:0];
                cf = wide[32];
                of = (a[31] == b[31]) && (res[31] != a[31]);
                af = ((a % 16) + (b % 16)) > 15;
                wr = F_CF | F_PF | F_AF | F_ZF | F_SF | F_OF;
            end
            3'd1: begin res = a & b; wr = F_CF | F_PF | F_AF | F_ZF | F_SF | F_OF; end
            3'd2: begin res = a | b; wr = F_CF | F_PF | F_AF | F_ZF | F_SF | F_OF; end
            3'd3: res = ~a;
            3'd4: if (c > 0) begin
                res = a << c;
                cf = a[W - c];
                of = res[31] ^ cf;
                wr = F_CF | F_PF | F_ZF | F_SF | ((c == 1) ? F_OF : 18'h0);
                lat = c + 1;
            end
            3'd5: if (c > 0) begin
                res = 32'($signed(a) >>> c);
                cf = a[c - 1];
                of = 1'b0;
                wr = F_CF | F_PF | F_ZF | F_SF | ((c == 1) ? F_OF : 18'h0);
                lat = c + 1;
            end
            3'd6: begin
                wr = F_ZF;
                if (b == 0) begin
                    lat = W / 4 + 1;
                end else begin
                    idx = 0;
                    for (int i = W - 1; i >= 0; i--) if (b[i]) idx = i;
                    res = idx;
                    lat = idx / 4 + 2;
                end
            end
            default: res = b;
        endcase
        nf = '0;
        nf[0] = cf;
        nf[1] = ~^res[7:0];
        nf[2] = af;
        nf[3] = (o == 3'd6) ? (b == 0) : (res == 0);
        nf[4] = res[31];
        nf[8] = of;
    endfunction

    task automatic offer(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] sh, input logic [17:0] fm);
        bus.op = o; bus.op1 = a; bus.op2 = b; bus.shcnt = sh; bus.fmask = fm;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
    endtask

    task automatic recover();
        @(posedge clk) #1 rst = 1'b1;
        @(posedge clk) #1 rst = 1'b0;
        exp_eflags = '0;
        @(negedge clk);
    endtask

    // Entered and left just after a falling edge with the unit idle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] sh, input logic [17:0] fm, input int stall,
                          input string tag);
        logic [31:0] res;
        logic [17:0] nf, wr;
        int lat, cyc;
        model(o, a, b, sh, res, nf, wr, lat);
        bus.ready_in = 1'b0;
        offer(o, a, b, sh, fm);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.valid_out && cyc < 100);
        n_checks++;
        if (bus.valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: valid_out never rose, expected after %0d cycles", tag, lat);
            recover();
            return;
        end
        n_checks++;
        if (cyc !== lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", tag, cyc, lat);
        end
        n_checks++;
        if (bus.result !== res) begin
            n_fail++;
            $display("FAIL %s result: got %h expected %h", tag, bus.result, res);
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            n_checks++;
            if (bus.valid_out !== 1'b1 || bus.result !== res || bus.eflags !== exp_eflags ||
                bus.ready_out !== 1'b0) begin
                n_fail++;
                $display("FAIL %s stall%0d: valid=%b result=%h eflags=%h, expected 1 %h %h",
                         tag, s, bus.valid_out, bus.result, bus.eflags, res, exp_eflags);
            end
        end
        bus.ready_in = 1'b1;
        @(posedge clk);
        #1 bus.ready_in = 1'b0;
        exp_eflags = (exp_eflags & ~(fm & wr)) | (nf & fm & wr);
        @(negedge clk);
        n_checks++;
        if (bus.eflags !== exp_eflags) begin
            n_fail++;
            $display("FAIL %s eflags: got %h expected %h", tag, bus.eflags, exp_eflags);
        end
        n_checks++;
        if (bus.ready_out !== 1'b1 || bus.valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post-handoff: ready_out=%b valid_out=%b expected 1 0",
                     tag, bus.ready_out, bus.valid_out);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.valid_out !== 1'b0 || bus.result !== 32'h0 || bus.eflags !== 18'h0 ||
            bus.busy !== 1'b0 || bus.ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: valid=%b result=%h eflags=%h busy=%b ready=%b expected 0 0 0 0 1",
                     bus.valid_out, bus.result, bus.eflags, bus.busy, bus.ready_out);
        end
        rst = 1'b0;
        exp_eflags = '0;
    endtask

    task automatic test_add();
        run_op(3'd0, 32'h7FFF_FFFF, 32'h1, 6'd0, 18'h3FFFF, 0, "add_ovf");
        n_checks++;
        if (bus.eflags !== (F_PF | F_AF | F_SF | F_OF)) begin
            n_fail++;
            $display("FAIL add_ovf flags: got %h expected %h", bus.eflags, F_PF | F_AF | F_SF | F_OF);
        end
        run_op(3'd1, 32'hF0F0_0000, 32'h0F0F_FFFF, 6'd0, 18'h3FFFF, 0, "and_zero");
        run_op(3'd2, 32'h0000_0081, 32'h0000_0002, 6'd0, 18'h3FFFF, 0, "or");
        run_op(3'd3, 32'h1234_5678, 32'h0, 6'd0, 18'h3FFFF, 0, "not");
        run_op(3'd7, 32'h1234_5678, 32'hCAFE_0001, 6'd0, 18'h3FFFF, 0, "pass");
    endtask

    task automatic test_shift();
        run_op(3'd4, 32'h8000_0001, 32'h0, 6'd1, 18'h3FFFF, 0, "sal1");
        n_checks++;
        if ((bus.eflags & (F_CF | F_OF)) !== (F_CF | F_OF)) begin
            n_fail++;
            $display("FAIL sal1 cf_of: got %h expected CF and OF set", bus.eflags);
        end
        run_op(3'd4, 32'h8000_0001, 32'h0, 6'd33, 18'h3FFFF, 0, "sal33");
        run_op(3'd5, 32'h8000_0000, 32'h0, 6'd4, 18'h3FFFF, 0, "sar4");
        run_op(3'd5, 32'h0123_4567, 32'h0, 6'd0, 18'h3FFFF, 0, "sar0");
        run_op(3'd4, 32'hFFFF_FFFF, 32'h0, 6'd31, 18'h3FFFF, 0, "sal31");
    endtask

    task automatic test_bsf();
        run_op(3'd6, 32'h5555_AAAA, 32'h0000_0100, 6'd0, 18'h3FFFF, 0, "bsf8");
        run_op(3'd6, 32'h5555_AAAA, 32'h0, 6'd0, 18'h3FFFF, 0, "bsf_zero");
        run_op(3'd6, 32'h0, 32'h8000_0000, 6'd0, 18'h3FFFF, 0, "bsf31");
        run_op(3'd6, 32'h0, 32'h0000_0001, 6'd0, 18'h3FFFF, 0, "bsf0");
    endtask

    task automatic test_backpressure();
        run_op(3'd0, 32'hFFFF_FFFF, 32'h1, 6'd0, 18'h3FFFF, 5, "add_stall");
        run_op(3'd4, 32'h4000_0003, 32'h0, 6'd2, 18'h0000B, 3, "sal_stall_masked");
    endtask

    task automatic test_flush();
        logic seen;
        // Flush in IDLE blocks acceptance.
        bus.flush = 1'b1;
        bus.ready_in = 1'b0;
        offer(3'd0, 32'h1, 32'h1, 6'd0, 18'h3FFFF);
        bus.flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_idle: valid=%b ready=%b expected 0 1", bus.valid_out, bus.ready_out);
        end
        // Flush during a 10-cycle SAL at cycle 3.
        offer(3'd4, 32'hFFFF_0000, 32'h0, 6'd10, 18'h3FFFF);
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sal_busy: got busy=%b expected 1", bus.busy);
        end
        @(negedge clk);
        @(posedge clk) #1 bus.flush = 1'b1;
        @(posedge clk) #1 bus.flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.ready_out !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy: ready=%b busy=%b expected 1 0", bus.ready_out, bus.busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (bus.valid_out) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 1'b0 || bus.eflags !== exp_eflags) begin
            n_fail++;
            $display("FAIL flush_quiet: valid seen=%b eflags=%h expected 0 %h", seen, bus.eflags, exp_eflags);
        end
        // Flush wins over a simultaneous handoff.
        offer(3'd0, 32'h0, 32'h0, 6'd0, 18'h3FFFF);
        @(negedge clk);
        bus.ready_in = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk) #1;
        bus.ready_in = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.valid_out !== 1'b0 || bus.eflags !== exp_eflags || bus.ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_done: valid=%b eflags=%h ready=%b expected 0 %h 1",
                     bus.valid_out, bus.eflags, bus.ready_out, exp_eflags);
        end
    endtask

    task automatic test_reset_mid_bsf();
        logic seen;
        offer(3'd6, 32'h1234_5678, 32'h0, 6'd0, 18'h3FFFF);
        repeat (3) @(negedge clk);
        @(posedge clk) #1 rst = 1'b1;
        @(posedge clk) #1 rst = 1'b0;
        exp_eflags = '0;
        @(negedge clk);
        n_checks++;
        if (bus.valid_out !== 1'b0 || bus.result !== 32'h0 || bus.eflags !== 18'h0 ||
            bus.busy !== 1'b0 || bus.ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_bsf: valid=%b result=%h eflags=%h busy=%b ready=%b expected 0 0 0 0 1",
                     bus.valid_out, bus.result, bus.eflags, bus.busy, bus.ready_out);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.valid_out) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_bsf_quiet: valid seen=%b expected 0", seen);
        end
    endtask

    task automatic test_random();
        logic [2:0] o;
        logic [31:0] a, b;
        for (int n = 0; n < 60; n++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'h0;
                1: b = 32'h1 << $urandom_range(0, 31);
                2: b = $urandom & ($urandom << $urandom_range(0, 31));
                default: b = $urandom;
            endcase
            run_op(o, a, b, 6'($urandom_range(0, 63)), 18'($urandom), $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.op = '0;
        bus.op1 = '0;
        bus.op2 = '0;
        bus.shcnt = '0;
        bus.fmask = '0;
        bus.flush = 1'b0;
        bus.ready_in = 1'b0;
        test_reset();
        test_add();
        test_shift();
        test_bsf();
        test_backpressure();
        test_flush();
        test_reset_mid_bsf();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
